shift_seq_ctrl: RTL and testbench



---
 rtl/alu_pkg.sv | 18 +
 rtl/shift_reg.sv | 35 +++
 rtl/shift_seq_ctrl.sv | 113 +++++++++++
 tb/tb_shift_seq_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants: operand width, shift op encoding, sequencer states
package alu_pkg;

  localparam int DATA_W = 8;

  // Step-unit op encoding, driven to the step unit as {s3,s2}
  localparam logic [1:0] OP_ROR = 2'b00;
  localparam logic [1:0] OP_SHR = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_SHL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    STEP = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/shift_reg.sv
// rtl/shift_reg.sv - single-step combinational shift/rotate datapath
module shift_reg
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] i_d,
  input  logic [1:0]        i_op,
  output logic [DATA_W-1:0] o_q,
  output logic              o_out_bit
);

  // One position per evaluation; o_out_bit is the bit that leaves the word
  always_comb begin
    o_q       = i_d;
    o_out_bit = 1'b0;
    case (i_op)
      OP_ROR: begin
        o_q       = {i_d[0], i_d[DATA_W-1:1]};
        o_out_bit = i_d[0];
      end
      OP_SHR: begin
        o_q       = {1'b0, i_d[DATA_W-1:1]};
        o_out_bit = i_d[0];
      end
      OP_ROL: begin
        o_q       = {i_d[DATA_W-2:0], i_d[DATA_W-1]};
        o_out_bit = i_d[DATA_W-1];
      end
      default: begin
        o_q       = {i_d[DATA_W-2:0], 1'b0};
        o_out_bit = i_d[DATA_W-1];
      end
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - multi-cycle shift/rotate sequencer; optional carry output under SHIFT_SEQ_CARRY_EN
module shift_seq_ctrl
  import alu_pkg::*;
#(
  parameter int AMT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [1:0]        op,
  input  logic [AMT_W-1:0]  amt,
  output logic              busy,
  output logic              done,
`ifdef SHIFT_SEQ_CARRY_EN
  output logic              carry,
`endif
  output logic [DATA_W-1:0] result
);

  state_t             r_state;
  state_t             w_next_state;
  logic [DATA_W-1:0]  r_acc;
  logic [AMT_W-1:0]   r_cnt;
  logic [1:0]         r_op;
  logic [DATA_W-1:0]  w_step;
`ifdef SHIFT_SEQ_CARRY_EN
  logic               r_carry;
  logic               w_out_bit;
`endif

  // The step unit always sees the accumulator and the captured op
  shift_reg u_shift_reg (
    .i_d       (r_acc),
    .i_op      (r_op),
    .o_q       (w_step),
`ifdef SHIFT_SEQ_CARRY_EN
    .o_out_bit (w_out_bit)
`else
    .o_out_bit ()
`endif
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: amt==0 goes straight to DONE; last step is the one seen with cnt==1
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = (amt != '0) ? STEP : DONE;
        end
      end
      STEP: begin
        if (r_cnt == AMT_W'(1)) begin
          w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: capture on accepted start, recirculate one step per STEP cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
`ifdef SHIFT_SEQ_CARRY_EN
      r_carry <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc   <= a;
            r_cnt   <= amt;
            r_op    <= op;
`ifdef SHIFT_SEQ_CARRY_EN
            r_carry <= 1'b0;
`endif
          end
        end
        STEP: begin
          r_acc   <= w_step;
          r_cnt   <= r_cnt - AMT_W'(1);
`ifdef SHIFT_SEQ_CARRY_EN
          r_carry <= w_out_bit;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign busy   = (r_state != IDLE);
  assign done   = (r_state == DONE);
  assign result = r_acc;
`ifdef SHIFT_SEQ_CARRY_EN
  assign carry  = r_carry;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - scoreboard bench for shift_seq_ctrl with a behavioural shift model
module tb_shift_seq_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [1:0] op = 2'b00;
  logic [2:0] amt = 3'd0;
  logic       busy;
  logic       done;
  logic [7:0] result;
`ifdef SHIFT_SEQ_CARRY_EN
  logic       carry;
`endif

  shift_seq_ctrl #(.AMT_W(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .op     (op),
    .amt    (amt),
    .busy   (busy),
    .done   (done),
`ifdef SHIFT_SEQ_CARRY_EN
    .carry  (carry),
`endif
    .result (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] a;
    logic [1:0] op;
    int         amt;
    int         c0;
  } txn_t;

  txn_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] last_res = 8'h00;
  logic       last_carry = 1'b0;

  // Value after k single-position moves, computed as a whole-word operation
  function automatic logic [7:0] model_res(logic [7:0] v, logic [1:0] o, int k);
    logic [15:0] w;
    logic [7:0]  r;
    w = {v, v};
    case (o)
      2'b00: begin w = w >> k; r = w[7:0]; end
      2'b01: r = v >> k;
      2'b10: begin w = w << k; r = w[15:8]; end
      default: r = v << k;
    endcase
    return r;
  endfunction

  // Last bit to leave the word after k moves (0 when nothing moved)
  function automatic logic model_carry(logic [7:0] v, logic [1:0] o, int k);
    if (k == 0) return 1'b0;
    if (o[1] == 1'b0) return v[k-1];
    return v[8-k];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle checks the active transaction's step k, or idle hold behaviour
  always @(negedge clk) begin : monitor
    txn_t t;
    int   k;
    if (rst_n) begin
      if (sb.size() > 0 && cyc >= sb[0].c0) begin
        t = sb[0];
        k = cyc - t.c0;
        chk("result_step", result, model_res(t.a, t.op, k));
        chk("busy_active", busy, 1);
        chk("done_flag", done, (k == t.amt));
`ifdef SHIFT_SEQ_CARRY_EN
        chk("carry_step", carry, model_carry(t.a, t.op, k));
`endif
        if (k >= t.amt) begin
          last_res   = model_res(t.a, t.op, t.amt);
          last_carry = model_carry(t.a, t.op, t.amt);
          void'(sb.pop_front());
        end
      end else begin
        chk("busy_idle", busy, 0);
        chk("done_idle", done, 0);
        chk("result_hold", result, last_res);
`ifdef SHIFT_SEQ_CARRY_EN
        chk("carry_hold", carry, last_carry);
`endif
      end
    end
  end

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while (busy && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic issue(input logic [7:0] va, input logic [1:0] vo, input logic [2:0] vamt);
    txn_t t;
    wait_idle();
    start = 1'b1;
    a     = va;
    op    = vo;
    amt   = vamt;
    t.a = va; t.op = vo; t.amt = int'(vamt); t.c0 = cyc + 1;
    sb.push_back(t);
    @(negedge clk);
    start = 1'b0;
    a     = 8'($urandom);
    op    = 2'($urandom_range(3, 0));
    amt   = 3'($urandom_range(7, 0));
  endtask

  task automatic do_reset_check(input string tag);
    chk({tag, "_result"}, result, 8'h00);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
`ifdef SHIFT_SEQ_CARRY_EN
    chk({tag, "_carry"}, carry, 0);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    txn_t t;
    int   n0;
    #2;
    do_reset_check("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    issue(8'h96, 2'b10, 3'd3);
    issue(8'h96, 2'b01, 3'd2);
    issue(8'h01, 2'b00, 3'd1);
    issue(8'h5C, 2'b00, 3'd0);
    issue(8'hFF, 2'b11, 3'd7);
    repeat (2) @(negedge clk);
    start = 1'b1;
    a     = 8'h00;
    @(negedge clk);
    start = 1'b0;

    // Start held high: accepted every amt+2 cycles
    wait_idle();
    start = 1'b1; a = 8'h3C; op = 2'b10; amt = 3'd1;
    n0 = cyc;
    for (int i = 0; i < 3; i++) begin
      t.a = 8'h3C; t.op = 2'b10; t.amt = 1; t.c0 = n0 + 1 + 3 * i;
      sb.push_back(t);
    end
    repeat (7) @(negedge clk);
    start = 1'b0;

    // Asynchronous reset in the middle of a 7-step op
    issue(8'hA5, 2'b11, 3'd7);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 do_reset_check("midreset");
    sb.delete();
    last_res   = 8'h00;
    last_carry = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'hC3, 2'b00, 3'd5);

    // Randomised operations with random gaps
    for (int i = 0; i < 40; i++) begin
      issue(8'($urandom), 2'($urandom_range(3, 0)), 3'($urandom_range(7, 0)));
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end

    begin
      int w = 0;
      while (sb.size() > 0 && w < 100) begin
        @(negedge clk);
        w++;
      end
    end
    if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
